// File: rtl/capture_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer_if
//  Purpose  : Groups the sample/command inputs and RAM-write/status outputs
//             of the capture sequencer into one bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface capture_sequencer_if #(
  parameter int INDEX_WIDTH = 60,
  parameter int ADDR_WIDTH  = 12
);
  // command, sample stream and capture setup
  logic                   cmd_arm;
  logic                   cmd_abort;
  logic                   trigger;
  logic [15:0]            sample;
  logic                   sample_strobe;
  logic [INDEX_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0]  pre_words;
  logic [INDEX_WIDTH-1:0] post_count;
  // RAM write port and capture status
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [15:0]            wr_data;
  logic [ADDR_WIDTH-1:0]  trig_addr;
  logic [INDEX_WIDTH-1:0] trig_index;
  logic [2:0]             state;
  logic                   done;
  logic                   overflow;

  // source / controller side
  modport master (
    output cmd_arm, cmd_abort, trigger, sample, sample_strobe, index, pre_words, post_count,
    input  wr_en, wr_addr, wr_data, trig_addr, trig_index, state, done, overflow
  );

  // sequencer side
  modport slave (
    input  cmd_arm, cmd_abort, trigger, sample, sample_strobe, index, pre_words, post_count,
    output wr_en, wr_addr, wr_data, trig_addr, trig_index, state, done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer
//  Purpose  : Runs one logic-analyser capture (arm, pre-trigger fill, wait
//             for trigger, post-trigger record, stop) and drives the ring
//             buffer write port.
//  Revision : 1.0  initial release
// ============================================================================
module capture_sequencer #(
  parameter int INDEX_WIDTH = 60,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic               clk,
  input  logic               rst,
  capture_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q,        state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q,          ptr_d;
  logic [ADDR_WIDTH-1:0]  pre_cnt_q,      pre_cnt_d;
  logic [ADDR_WIDTH-1:0]  pre_words_q,    pre_words_d;
  logic [INDEX_WIDTH-1:0] post_count_q,   post_count_d;
  logic [ADDR_WIDTH-1:0]  trig_addr_q,    trig_addr_d;
  logic [INDEX_WIDTH-1:0] trig_index_q,   trig_index_d;
  logic                   wr_en_q,        wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q,      wr_addr_d;
  logic [15:0]            wr_data_q,      wr_data_d;
  logic                   done_q,         done_d;
  logic                   overflow_q,     overflow_d;
  logic                   post_written_q, post_written_d;

  logic [ADDR_WIDTH-1:0]  pre_cnt_next;
  logic [INDEX_WIDTH-1:0] post_dist;
  logic                   do_write;

  // Next-state, write decision and pointer bookkeeping
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    pre_cnt_d      = pre_cnt_q;
    pre_words_d    = pre_words_q;
    post_count_d   = post_count_q;
    trig_addr_d    = trig_addr_q;
    trig_index_d   = trig_index_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    done_d         = 1'b0;
    overflow_d     = overflow_q;
    post_written_d = post_written_q;
    do_write       = 1'b0;
    pre_cnt_next   = pre_cnt_q;
    // distance travelled since the trigger, modulo the index width
    post_dist      = bus.index - trig_index_q;

    if (bus.cmd_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.cmd_arm) begin
            ptr_d          = '0;
            pre_cnt_d      = '0;
            overflow_d     = 1'b0;
            post_written_d = 1'b0;
            pre_words_d    = bus.pre_words;
            post_count_d   = bus.post_count;
            // no history requested: go straight to waiting for the trigger
            state_d        = (bus.pre_words == '0) ? S_ARMED : S_PRETRIG;
          end
        end
        S_PRETRIG: begin
          do_write = bus.sample_strobe;
          if (bus.sample_strobe && (pre_cnt_q != pre_words_q))
            pre_cnt_next = pre_cnt_q + 1'b1;
          pre_cnt_d = pre_cnt_next;
          if (pre_cnt_next == pre_words_q)
            state_d = S_ARMED;
        end
        S_ARMED: begin
          // a coincident strobe is the trigger word and lands at trig_addr
          do_write = bus.sample_strobe;
          if (bus.trigger) begin
            state_d        = S_POST;
            trig_addr_d    = ptr_q;
            trig_index_d   = bus.index;
            post_written_d = 1'b0;
          end
        end
        S_POST: begin
          if (post_dist >= post_count_q) begin
            state_d = S_DONE;
          end else if (bus.sample_strobe) begin
            // writing here again would overwrite the trigger word
            if (post_written_q && (ptr_q == trig_addr_q)) begin
              state_d    = S_DONE;
              overflow_d = 1'b1;
            end else begin
              do_write       = 1'b1;
              post_written_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = bus.sample;
      ptr_d     = ptr_q + 1'b1;
    end

    if ((state_d == S_DONE) && (state_q != S_DONE))
      done_d = 1'b1;
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      pre_cnt_q      <= '0;
      pre_words_q    <= '0;
      post_count_q   <= '0;
      trig_addr_q    <= '0;
      trig_index_q   <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      post_written_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      pre_cnt_q      <= pre_cnt_d;
      pre_words_q    <= pre_words_d;
      post_count_q   <= post_count_d;
      trig_addr_q    <= trig_addr_d;
      trig_index_q   <= trig_index_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
      post_written_q <= post_written_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.trig_index = trig_index_q;
  assign bus.state      = state_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_sequencer
//  Purpose  : Directed, table-driven self-checking bench for capture_sequencer
//             (8-word ring so wrap and overflow are reachable quickly).
//  Revision : 1.0  initial release
// ============================================================================
module tb_capture_sequencer;

  localparam int IW = 60;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  capture_sequencer_if #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  capture_sequencer #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          arm;
    logic          abort;
    logic          trig;
    logic          stb;
    logic [15:0]   smp;
    logic [IW-1:0] idx;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_data;
    logic [2:0]    exp_state;
    logic          exp_done;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic a, input logic ab, input logic tr, input logic st,
                              input logic [15:0] sm, input logic [IW-1:0] ix,
                              input logic ew, input logic [AW-1:0] ea, input logic [15:0] ed,
                              input logic [2:0] es, input logic edn);
    vec_t v;
    v.arm = a; v.abort = ab; v.trig = tr; v.stb = st; v.smp = sm; v.idx = ix;
    v.exp_wen = ew; v.exp_addr = ea; v.exp_data = ed; v.exp_state = es; v.exp_done = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // apply one cycle of inputs, then sample the registered outputs just after the edge
  task automatic cyc(input logic a, input logic ab, input logic tr, input logic st,
                     input logic [15:0] sm, input logic [IW-1:0] ix);
    bus.cmd_arm       = a;
    bus.cmd_abort     = ab;
    bus.trigger       = tr;
    bus.sample_strobe = st;
    bus.sample        = sm;
    bus.index         = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_basic(input string nm, input logic ew, input logic [AW-1:0] ea,
                           input logic [2:0] es, input logic edn);
    chk({nm, ".wr_en"},   64'(bus.wr_en),   64'(ew));
    chk({nm, ".wr_addr"}, 64'(bus.wr_addr), 64'(ea));
    chk({nm, ".state"},   64'(bus.state),   64'(es));
    chk({nm, ".done"},    64'(bus.done),    64'(edn));
  endtask

  task automatic chk_all_zero(input string nm);
    chk_basic(nm, 1'b0, '0, 3'd0, 1'b0);
    chk({nm, ".wr_data"},    64'(bus.wr_data),    64'd0);
    chk({nm, ".trig_addr"},  64'(bus.trig_addr),  64'd0);
    chk({nm, ".trig_index"}, 64'(bus.trig_index), 64'd0);
    chk({nm, ".overflow"},   64'(bus.overflow),   64'd0);
  endtask

  initial begin
    logic [IW-1:0] base;

    bus.pre_words  = '0;
    bus.post_count = '0;
    cyc(0, 0, 0, 0, 16'h0, '0);
    cyc(0, 0, 0, 0, 16'h0, '0);
    cyc(0, 0, 0, 0, 16'h0, '0);
    chk_all_zero("reset");
    rst = 1'b0;

    // ---- main capture: pre 4, post 3, continuous strobes, trigger on 6th ----
    tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 60'd0,  0, 3'd0, 16'h0000, 3'd1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 16'hA001, 60'd1,  1, 3'd0, 16'hA001, 3'd1, 0);
    tbl[2]  = mk(0, 0, 1, 1, 16'hA002, 60'd2,  1, 3'd1, 16'hA002, 3'd1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 16'hA003, 60'd3,  1, 3'd2, 16'hA003, 3'd1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 16'hA004, 60'd4,  1, 3'd3, 16'hA004, 3'd2, 0);
    tbl[5]  = mk(0, 0, 0, 1, 16'hA005, 60'd5,  1, 3'd4, 16'hA005, 3'd2, 0);
    tbl[6]  = mk(0, 0, 1, 1, 16'hA006, 60'd6,  1, 3'd5, 16'hA006, 3'd3, 0);
    tbl[7]  = mk(0, 0, 0, 1, 16'hA007, 60'd7,  1, 3'd6, 16'hA007, 3'd3, 0);
    tbl[8]  = mk(0, 0, 0, 1, 16'hA008, 60'd8,  1, 3'd7, 16'hA008, 3'd3, 0);
    tbl[9]  = mk(0, 0, 0, 1, 16'hA009, 60'd9,  0, 3'd7, 16'hA008, 3'd4, 1);
    tbl[10] = mk(0, 0, 0, 0, 16'h0000, 60'd9,  0, 3'd7, 16'hA008, 3'd4, 0);
    tbl[11] = mk(0, 0, 1, 1, 16'hA00A, 60'd10, 0, 3'd7, 16'hA008, 3'd4, 0);

    bus.pre_words  = 3'd4;
    bus.post_count = 60'd3;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].arm, tbl[i].abort, tbl[i].trig, tbl[i].stb, tbl[i].smp, tbl[i].idx);
      chk_basic($sformatf("vec%0d", i), tbl[i].exp_wen, tbl[i].exp_addr,
                tbl[i].exp_state, tbl[i].exp_done);
      chk($sformatf("vec%0d.wr_data", i), 64'(bus.wr_data), 64'(tbl[i].exp_data));
    end
    chk("main.trig_addr",  64'(bus.trig_addr),  64'd5);
    chk("main.trig_index", 64'(bus.trig_index), 64'd6);
    chk("main.overflow",   64'(bus.overflow),   64'd0);

    // ---- re-arm from DONE, trigger held from arm; arm mid-capture ignored ----
    bus.pre_words  = 3'd4;
    bus.post_count = 60'd50;
    cyc(1, 0, 1, 0, 16'h0, 60'd0);
    chk_basic("hold.arm", 0, 3'd7, 3'd1, 0);
    for (int n = 1; n <= 4; n++) begin
      cyc((n == 2), 0, 1, 1, 16'hB000 + 16'(n), 60'(n));
      chk_basic($sformatf("hold.w%0d", n), 1, 3'(n - 1), (n < 4) ? 3'd1 : 3'd2, 0);
    end
    cyc(0, 0, 1, 1, 16'hB005, 60'd5);
    chk_basic("hold.trig", 1, 3'd4, 3'd3, 0);
    chk("hold.trig_addr",  64'(bus.trig_addr),  64'd4);
    chk("hold.trig_index", 64'(bus.trig_index), 64'd5);

    // ---- abort in POST with a coincident strobe ----
    cyc(0, 1, 0, 1, 16'hB006, 60'd6);
    chk_basic("abort", 0, 3'd4, 3'd0, 0);
    cyc(0, 0, 0, 1, 16'hB007, 60'd7);
    chk_basic("abort.after", 0, 3'd4, 3'd0, 0);
    chk("abort.trig_addr", 64'(bus.trig_addr), 64'd4);
    cyc(1, 1, 0, 0, 16'h0, 60'd7);
    chk("abort_arm.state", 64'(bus.state), 64'd0);

    // ---- pre 0, run-length jump of 100 across the index wrap, post 10 ----
    base           = 60'hFFF_FFFF_FFFF_FFFA;
    bus.pre_words  = 3'd0;
    bus.post_count = 60'd10;
    cyc(1, 0, 0, 0, 16'h0, base);
    chk("rl.arm.state", 64'(bus.state), 64'd2);
    cyc(1, 0, 1, 1, 16'hC000, base);
    chk_basic("rl.trig", 1, 3'd0, 3'd3, 0);
    chk("rl.trig_index", 64'(bus.trig_index), 64'(base));
    cyc(0, 0, 0, 1, 16'hC001, base + 60'd1);
    chk_basic("rl.w1", 1, 3'd1, 3'd3, 0);
    cyc(0, 0, 0, 1, 16'hC002, base + 60'd101);
    chk_basic("rl.jump", 0, 3'd1, 3'd4, 1);
    cyc(0, 0, 0, 1, 16'hC003, base + 60'd102);
    chk_basic("rl.after", 0, 3'd1, 3'd4, 0);

    // ---- post_count 0: trigger word only ----
    bus.post_count = 60'd0;
    cyc(1, 0, 0, 0, 16'h0, 60'd4);
    chk("pc0.arm.state", 64'(bus.state), 64'd2);
    cyc(0, 0, 1, 1, 16'hD000, 60'd5);
    chk_basic("pc0.trig", 1, 3'd0, 3'd3, 0);
    cyc(0, 0, 0, 1, 16'hD001, 60'd6);
    chk_basic("pc0.done", 0, 3'd0, 3'd4, 1);

    // ---- ring wrap onto trig_addr: pre 2, post 1000 ----
    bus.pre_words  = 3'd2;
    bus.post_count = 60'd1000;
    cyc(1, 0, 0, 0, 16'h0, 60'd0);
    cyc(0, 0, 0, 1, 16'hE001, 60'd1);
    chk_basic("ovf.pre1", 1, 3'd0, 3'd1, 0);
    cyc(0, 0, 0, 1, 16'hE002, 60'd2);
    chk_basic("ovf.pre2", 1, 3'd1, 3'd2, 0);
    cyc(0, 0, 1, 0, 16'h0, 60'd2);
    chk_basic("ovf.trig", 0, 3'd1, 3'd3, 0);
    chk("ovf.trig_addr", 64'(bus.trig_addr), 64'd2);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 1, 16'hE100 + 16'(k), 60'(3 + k));
      chk_basic($sformatf("ovf.post%0d", k), 1, 3'((2 + k) % 8), 3'd3, 0);
    end
    cyc(0, 0, 0, 1, 16'hE1FF, 60'd11);
    chk_basic("ovf.stop", 0, 3'd1, 3'd4, 1);
    chk("ovf.overflow", 64'(bus.overflow), 64'd1);
    cyc(0, 0, 0, 0, 16'h0, 60'd11);
    chk("ovf.sticky", 64'(bus.overflow), 64'd1);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 16'h0, 60'd0);
    rst = 1'b0;
    chk_all_zero("ovf.rst");

    // ---- reset in POST, then a fresh capture restarts at address 0 ----
    bus.pre_words  = 3'd1;
    bus.post_count = 60'd50;
    cyc(1, 0, 0, 0, 16'h0, 60'd19);
    cyc(0, 0, 0, 1, 16'hF001, 60'd20);
    chk_basic("rstpost.pre", 1, 3'd0, 3'd2, 0);
    cyc(0, 0, 1, 1, 16'hF002, 60'd21);
    chk_basic("rstpost.trig", 1, 3'd1, 3'd3, 0);
    chk("rstpost.trig_index", 64'(bus.trig_index), 64'd21);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 16'hF003, 60'd22);
    rst = 1'b0;
    chk_all_zero("rstpost.rst");
    bus.pre_words = 3'd0;
    cyc(1, 0, 0, 0, 16'h0, 60'd30);
    chk("rstpost.rearm", 64'(bus.state), 64'd2);
    cyc(0, 0, 1, 1, 16'hF004, 60'd31);
    chk_basic("rstpost.first", 1, 3'd0, 3'd3, 0);
    chk("rstpost.trig_addr", 64'(bus.trig_addr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
